// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage and future bus-master stages: stall
// encodings, zero constants and the 2-bit bus handshake state encoding.
package mem_stage_pkg;

  localparam logic        STOP      = 1'b1;
  localparam logic        NOSTOP    = 1'b0;
  localparam logic        ZERO_BIT  = 1'b0;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  localparam int STALL_MEM_IDX = 4;

  typedef enum logic [1:0] {
    BUS_IDLE = 2'd0,
    BUS_REQ  = 2'd1,
    BUS_WAIT = 2'd2,
    BUS_DONE = 2'd3
  } bus_state_e;

  function automatic logic is_misaligned(input logic i_memop, input logic [1:0] i_lsb);
    return i_memop & (i_lsb != 2'b00);
  endfunction

endpackage

// File: rtl/mem_bus_fsm.sv
// Data-bus handshake engine: state register, req/addr_ok/data_ok sequencing
// and the load-data buffer that holds the result until MEM/WB accepts it.
module mem_bus_fsm
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic              i_load,
  input  logic              i_hold,
  input  logic              i_addr_ok,
  input  logic              i_data_ok,
  input  logic [DATA_W-1:0] i_rdata,
  output bus_state_e        o_state,
  output logic              o_req,
  output logic [DATA_W-1:0] o_rdata
);

  bus_state_e        r_state;
  bus_state_e        w_next;
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= BUS_IDLE;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == BUS_WAIT && i_data_ok && i_load) begin
        r_rdata <= i_rdata;
      end
    end
  end

  // data_ok is honoured only in WAIT; the bus never returns it with addr_ok.
  always_comb begin
    w_next = r_state;
    o_req  = 1'b0;
    case (r_state)
      BUS_IDLE: begin
        if (i_start) begin
          o_req  = 1'b1;
          w_next = i_addr_ok ? BUS_WAIT : BUS_REQ;
        end
      end
      BUS_REQ: begin
        o_req = 1'b1;
        if (i_addr_ok) begin
          w_next = BUS_WAIT;
        end
      end
      BUS_WAIT: begin
        if (i_data_ok) begin
          w_next = BUS_DONE;
        end
      end
      BUS_DONE: begin
        if (!i_hold) begin
          w_next = BUS_IDLE;
        end
      end
      default: w_next = BUS_IDLE;
    endcase
  end

  assign o_state = r_state;
  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: word load/store over an SRAM-like bus, stall request while a
// transaction is in flight, and the write-back/forwarding triple.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        stall,
  input  logic              i_write_mem,
  input  logic              i_write_regfile,
  input  logic              i_mem_to_regfile,
  input  logic [DATA_W-1:0] i_da,
  input  logic [DATA_W-1:0] i_db,
  input  logic [4:0]        i_rn,
  output logic              data_req,
  output logic              data_wr,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata,
  output logic              o_write_regfile,
  output logic [4:0]        o_rn,
  output logic [DATA_W-1:0] o_wdata,
  output logic              o_stallreq,
  output logic              o_addr_err
);

  logic              w_memop;
  logic              w_misalign;
  logic              w_start;
  logic              w_req;
  logic [DATA_W-1:0] w_buf;
  bus_state_e        w_state;

  assign w_memop    = i_write_mem | i_mem_to_regfile;
  assign w_misalign = is_misaligned(w_memop, i_da[1:0]);
  assign w_start    = w_memop & ~w_misalign;

  mem_bus_fsm #(.DATA_W(DATA_W)) u_fsm (
    .clk       (clk),
    .reset     (reset),
    .i_start   (w_start),
    .i_load    (i_mem_to_regfile),
    .i_hold    (stall[STALL_MEM_IDX] == STOP),
    .i_addr_ok (data_addr_ok),
    .i_data_ok (data_data_ok),
    .i_rdata   (data_rdata),
    .o_state   (w_state),
    .o_req     (w_req),
    .o_rdata   (w_buf)
  );

  assign o_stallreq = ((w_state == BUS_IDLE) & w_start)
                    | (w_state == BUS_REQ)
                    | (w_state == BUS_WAIT);
  assign o_addr_err = w_misalign & (w_state == BUS_IDLE);

  assign data_req   = w_req;
  assign data_wr    = w_req & i_write_mem;
  assign data_addr  = w_req ? {i_da[ADDR_W-1:2], 2'b00} : '0;
  assign data_wdata = w_req ? i_db : '0;

  // Stalled or faulting ops present a bubble; completed stores write nothing.
  always_comb begin
    o_write_regfile = ZERO_BIT;
    o_rn            = 5'd0;
    o_wdata         = '0;
    if (o_stallreq || o_addr_err) begin
      o_write_regfile = ZERO_BIT;
    end else if (w_state == BUS_DONE) begin
      if (i_mem_to_regfile) begin
        o_write_regfile = i_write_regfile;
        o_rn            = i_rn;
        o_wdata         = w_buf;
      end
    end else begin
      o_write_regfile = i_write_regfile;
      o_rn            = i_rn;
      o_wdata         = i_da;
    end
  end

endmodule
